// File: rtl/firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv
// rtl/firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv - IJTAG TDR driving the gate1 data-mux select/data override.
// Optional macro TDR_DMUX_PARITY_EN adds an odd-parity bit at SR[0] and rejects updates with bad parity.
module firebird7_in_gate1_tessent_tdr_dmux_ctrl #(
  parameter int                    DATA_WIDTH = 3,
  parameter logic                  SEL_RESET  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET = '0
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] functional_data_in,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out,
  output logic                  short_shift_err
);

`ifdef TDR_DMUX_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int L  = DATA_WIDTH + 1 + PW;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);

  logic [L-1:0]          sr_q, sr_d;
  logic                  ur_sel_q, ur_sel_d;
  logic [DATA_WIDTH-1:0] ur_data_q, ur_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [L-1:0]          cap_vec;
  logic                  parity_ok;

`ifdef TDR_DMUX_PARITY_EN
  // Parity bit makes select+data+parity an odd number of ones.
  assign cap_vec   = {ur_sel_q, functional_data_in, ~^{ur_sel_q, functional_data_in}};
  assign parity_ok = ^sr_q;
`else
  assign cap_vec   = {ur_sel_q, functional_data_in};
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    sr_d      = sr_q;
    ur_sel_d  = ur_sel_q;
    ur_data_d = ur_data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (ijtag_sel) begin
      if (ijtag_ce) begin
        sr_d  = cap_vec;
        cnt_d = '0;
      end else if (ijtag_se) begin
        sr_d  = {ijtag_si, sr_q[L-1:1]};
        cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
      end else if (ijtag_ue) begin
        if (cnt_q == CNT_FULL && parity_ok) begin
          ur_sel_d  = sr_q[L-1];
          ur_data_d = sr_q[L-2 -: DATA_WIDTH];
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_q      <= '0;
      ur_sel_q  <= SEL_RESET;
      ur_data_q <= DATA_RESET;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      ur_sel_q  <= ur_sel_d;
      ur_data_q <= ur_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign ijtag_so        = sr_q[0];
  assign ijtag_select    = ur_sel_q;
  assign ijtag_data_out  = ur_data_q;
  assign short_shift_err = err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv
// tb/tb_firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv - scoreboard bench with a bit-queue reference model.
module tb_firebird7_in_gate1_tessent_tdr_dmux_ctrl;

  localparam int DW = 3;
`ifdef TDR_DMUX_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int L = DW + 1 + PW;
  localparam logic SEL_RESET = 1'b0;
  localparam logic [DW-1:0] DATA_RESET = '0;

  logic          tck = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic [DW-1:0] fdi = '0;
  logic          so, osel, err;
  logic [DW-1:0] odata;

  firebird7_in_gate1_tessent_tdr_dmux_ctrl #(
    .DATA_WIDTH(DW), .SEL_RESET(SEL_RESET), .DATA_RESET(DATA_RESET)
  ) dut (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
    .functional_data_in(fdi), .ijtag_select(osel), .ijtag_data_out(odata),
    .short_shift_err(err)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic          sel;
    logic [DW-1:0] data;
    logic          so;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: the shift register is a queue whose front is the scan-out bit.
  bit          m_sr[$];
  logic        m_sel;
  logic [DW-1:0] m_data;
  int          m_cnt;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ones_in_sr();
    int n = 0;
    foreach (m_sr[i]) n += m_sr[i];
    return n;
  endfunction

  function automatic void model_reset();
    m_sr.delete();
    for (int i = 0; i < L; i++) m_sr.push_back(1'b0);
    m_sel  = SEL_RESET;
    m_data = DATA_RESET;
    m_cnt  = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit c, input bit sh, input bit u,
                                     input bit din, input logic [DW-1:0] f);
    int  n;
    bit  ok;
    if (!s) return;
    if (c) begin
      n = m_sel;
      for (int i = 0; i < DW; i++) n += f[i];
      m_sr.delete();
      if (PW == 1) m_sr.push_back((n % 2) == 0);
      for (int i = 0; i < DW; i++) m_sr.push_back(f[i]);
      m_sr.push_back(m_sel);
      m_cnt = 0;
    end else if (sh) begin
      void'(m_sr.pop_front());
      m_sr.push_back(din);
      if (m_cnt < L) m_cnt++;
    end else if (u) begin
      ok = (m_cnt == L);
      if (PW == 1) ok = ok && (ones_in_sr() % 2 == 1);
      if (ok) begin
        m_sel = m_sr[L-1];
        for (int i = 0; i < DW; i++) m_data[i] = m_sr[PW + i];
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.sel  = m_sel;
    e.data = m_data;
    e.so   = m_sr[0];
    e.err  = m_err;
    exp_q.push_back(e);
  endfunction

  task automatic op(input bit s, input bit c, input bit sh, input bit u,
                    input bit din, input logic [DW-1:0] f);
    @(negedge tck);
    rst_n = 1'b1;
    sel = s; ce = c; se = sh; ue = u; si = din; fdi = f;
    model_step(s, c, sh, u, din, f);
    push_exp();
  endtask

  task automatic hold_reset();
    @(negedge tck);
    rst_n = 1'b0;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
    model_reset();
    push_exp();
  endtask

  // Short low pulse between edges: only an asynchronous reset can see it.
  task automatic pulse_reset();
    @(negedge tck);
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    push_exp();
  endtask

  task automatic shift_bits(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) op(1, 0, 1, 0, v[i], fdi);
  endtask

  task automatic check_now(input string name, input logic s, input logic [DW-1:0] d, input logic e);
    @(posedge tck);
    #2;
    chk({name, "_select"}, osel, s);
    chk({name, "_data"}, odata, d);
    chk({name, "_err"}, err, e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge tck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_select", osel, e.sel);
        chk("sb_data", odata, e.data);
        chk("sb_so", so, e.so);
        chk("sb_err", err, e.err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stimulus
    model_reset();
    hold_reset();
    hold_reset();
`ifndef TDR_DMUX_PARITY_EN
    check_now("reset", 1'b0, 3'b000, 1'b0);
    op(1, 1, 0, 0, 0, 3'b000);
    shift_bits(4, 16'b1101);
    op(1, 0, 0, 1, 0, 3'b000);
    check_now("load", 1'b1, 3'b101, 1'b0);
`endif
    // Observe path: capture functional data, shift it out.
    op(1, 1, 0, 0, 0, 3'b110);
    shift_bits(L, 16'h0000);
    // Short shift then a valid update: error must stay sticky.
    op(1, 1, 0, 0, 0, 3'b011);
    shift_bits(2, 16'b11);
    op(1, 0, 0, 1, 0, 3'b011);
    op(1, 1, 0, 0, 0, 3'b001);
    shift_bits(L, 16'b10110);
    op(1, 0, 0, 1, 0, 3'b001);
    // Deselected: enables must be ignored.
    for (int i = 0; i < 6; i++) op(0, i[0], 1, ~i[0], 1, 3'b111);
    // Capture wins over shift, then over-length shift is accepted.
    op(1, 1, 1, 1, 1, 3'b010);
    op(1, 0, 0, 1, 0, 3'b010);
    hold_reset();
    op(1, 1, 0, 0, 0, 3'b000);
    shift_bits(L + 3, 16'b1010110);
    op(1, 0, 0, 1, 0, 3'b000);
    // Reset mid-shift, then update without a fresh shift.
    op(1, 1, 0, 0, 0, 3'b101);
    shift_bits(2, 16'b01);
    pulse_reset();
    op(1, 0, 0, 1, 0, 3'b101);
`ifndef TDR_DMUX_PARITY_EN
    check_now("midreset", 1'b0, 3'b000, 1'b1);
`else
    hold_reset();
    op(1, 1, 0, 0, 0, 3'b000);
    shift_bits(L, 16'b00000);
    op(1, 0, 0, 1, 0, 3'b000);
    check_now("parity_even", 1'b0, 3'b000, 1'b1);
`endif
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        if ($urandom_range(0, 1) == 0) pulse_reset();
        else hold_reset();
      end else begin
        op($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, DW'($urandom));
      end
    end
    @(negedge tck);
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
    repeat (3) @(negedge tck);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
